// File: rtl/edge_arb_pkg.sv
// Shared constants, FSM encoding and round-robin helper for the edge event arbiter.
package edge_arb_pkg;

  localparam int N_DEF     = 4;
  localparam int ID_W_DEF  = 2;
  localparam int EVT_CNT_W = 8;

  typedef enum logic {
    IDLE    = 1'b0,
    PRESENT = 1'b1
  } arb_state_e;

  // Pointer value that follows a grant to channel id among n channels.
  function automatic int rr_next(input int id, input int n);
    return (id + 1) % n;
  endfunction

endpackage

// File: rtl/edge_event_arbiter_if.sv
// Event output channel of the edge event arbiter.
interface edge_event_arbiter_if #(
  parameter int ID_W = 2
) ();

  // valid/ready: once evt_valid is high, evt_id stays stable until a cycle with
  // evt_ready high; the event is transferred on that rising edge.
  logic            evt_valid;
  logic            evt_ready;
  logic [ID_W-1:0] evt_id;

  modport master (
    output evt_valid,
    output evt_id,
    input  evt_ready
  );

  modport slave (
    input  evt_valid,
    input  evt_id,
    output evt_ready
  );

endinterface

// File: rtl/edge_event_arbiter_rr_pick.sv
// Combinational round-robin picker: first requester at or above rr_ptr, with wrap.
module rr_pick #(
  parameter int N    = 4,
  parameter int ID_W = 2
) (
  input  logic [N-1:0]    req,
  input  logic [ID_W-1:0] rr_ptr,
  output logic [N-1:0]    grant_oh,
  output logic [ID_W-1:0] grant_idx
);

  logic            found;
  logic [ID_W-1:0] cand;

  always_comb begin
    grant_oh  = '0;
    grant_idx = '0;
    found     = 1'b0;
    cand      = '0;
    for (int k = 0; k < N; k++) begin
      cand = ID_W'((int'(rr_ptr) + k) % N);
      if (!found && req[cand]) begin
        found          = 1'b1;
        grant_oh[cand] = 1'b1;
        grant_idx      = cand;
      end
    end
  end

endmodule

// File: rtl/edge_event_arbiter.sv
// Detects rising edges on N level lines and presents them one at a time,
// round-robin, on a valid/ready event channel with sticky overflow flags.
module edge_event_arbiter
  import edge_arb_pkg::*;
#(
  parameter int N    = N_DEF,
  parameter int ID_W = ID_W_DEF
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [N-1:0]         din,
  input  logic                 ovf_clr,
  edge_event_arbiter_if.master evt,
  output logic [N-1:0]         ovf,
  output logic [EVT_CNT_W-1:0] evt_cnt,
  output arb_state_e           state_dbg
);

  arb_state_e           state_q, state_n;
  logic [N-1:0]         din_q;
  logic [N-1:0]         pending_q, pending_n;
  logic [N-1:0]         ovf_q, ovf_n;
  logic [EVT_CNT_W-1:0] cnt_q, cnt_n;
  logic [ID_W-1:0]      rr_ptr_q, rr_ptr_n;
  logic [ID_W-1:0]      id_q, id_n;
  logic                 valid_q;

  logic [N-1:0]         rise;
  logic [N-1:0]         grant_oh;
  logic [N-1:0]         grant_vec;
  logic [ID_W-1:0]      grant_idx;
  logic                 grant_en;
  logic                 accept;

  rr_pick #(.N(N), .ID_W(ID_W)) u_rr_pick (
    .req       (pending_q),
    .rr_ptr    (rr_ptr_q),
    .grant_oh  (grant_oh),
    .grant_idx (grant_idx)
  );

  always_comb begin
    state_n  = state_q;
    grant_en = 1'b0;
    accept   = 1'b0;
    case (state_q)
      IDLE: begin
        if (|pending_q) begin
          grant_en = 1'b1;
          state_n  = PRESENT;
        end
      end
      PRESENT: begin
        if (evt.evt_ready) begin
          accept = 1'b1;
          if (|pending_q) grant_en = 1'b1;
          else            state_n  = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase

    rise      = din & ~din_q;
    grant_vec = grant_en ? grant_oh : '0;
    // A rise on the channel being granted re-arms it; a rise on an
    // already-pending, ungranted channel merges and flags overflow.
    pending_n = (pending_q & ~grant_vec) | rise;
    ovf_n     = (ovf_clr ? '0 : ovf_q) | (rise & pending_q & ~grant_vec);
    id_n      = grant_en ? grant_idx : id_q;
    rr_ptr_n  = grant_en ? ID_W'(rr_next(int'(grant_idx), N)) : rr_ptr_q;
    cnt_n     = accept ? cnt_q + EVT_CNT_W'(1) : cnt_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      valid_q   <= 1'b0;
      id_q      <= '0;
      ovf_q     <= '0;
      cnt_q     <= '0;
      pending_q <= '0;
      rr_ptr_q  <= '0;
      // Lines already high through reset must not look like fresh edges.
      din_q     <= '1;
    end else begin
      state_q   <= state_n;
      valid_q   <= (state_n == PRESENT);
      id_q      <= id_n;
      ovf_q     <= ovf_n;
      cnt_q     <= cnt_n;
      pending_q <= pending_n;
      rr_ptr_q  <= rr_ptr_n;
      din_q     <= din;
    end
  end

  assign evt.evt_valid = valid_q;
  assign evt.evt_id    = id_q;
  assign ovf           = ovf_q;
  assign evt_cnt       = cnt_q;
  assign state_dbg     = state_q;

endmodule
